// File: rtl/in_and_out_mux.sv
// in_and_out_mux: merges NUM_CH ready/valid producer channels onto one
// req/ack consumer port. Each channel is buffered in its own DEPTH-entry
// FIFO. A single output register holds the word being offered, tagged
// with its source channel. Arbitration is round-robin or fixed priority.
//
// Handshake semantics:
//   Input side  - a word moves on channel i at a rising edge where
//                 in_vld[i] && in_rdy[i]. in_rdy is a register derived only
//                 from the channel's next fill count. It never depends
//                 combinationally on in_vld or out_ack.
//   Output side - out_req stays high while the output register holds an
//                 unaccepted word. The word is consumed at a rising edge
//                 where out_req && out_ack. out_data and out_chan stay
//                 stable while out_req && !out_ack. out_ack is ignored
//                 while out_req is low.
module in_and_out_mux #(
  parameter int NUM_CH   = 4,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0,
  parameter int CW       = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    in_vld,
  output logic [NUM_CH-1:0]    in_rdy,
  input  logic [NUM_CH*DW-1:0] in_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [DW-1:0]        out_data,
  output logic [CW-1:0]        out_chan,
  output logic [NUM_CH-1:0]    ch_full,
  output logic [NUM_CH-1:0]    ch_empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = 1;
  localparam logic [AW-1:0] ONE_PTR  = 1;
  localparam logic [CW-1:0] ONE_CH   = 1;
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

  logic [DW-1:0]     mem     [NUM_CH][DEPTH];
  logic [AW-1:0]     wr_ptr  [NUM_CH];
  logic [AW-1:0]     rd_ptr  [NUM_CH];
  logic [AW:0]       cnt     [NUM_CH];
  logic [AW:0]       cnt_nxt [NUM_CH];

  logic [NUM_CH-1:0] ne;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] grant;
  logic              found;
  logic [CW-1:0]     gidx;
  logic [CW-1:0]     rr_ptr;
  logic              load;
  logic [DW-1:0]     head;

  // Status flags come straight from the count registers.
  always_comb begin
    ne       = '0;
    ch_full  = '0;
    ch_empty = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ne[k]       = (cnt[k] != '0);
      ch_empty[k] = (cnt[k] == '0);
      ch_full[k]  = (cnt[k] == FULL_CNT);
    end
  end

  // Arbitration. The first pass covers channels at or above rr_ptr. In
  // fixed-priority mode it covers all channels. The second pass wraps
  // round to the low channels.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && ne[k] && (ARB_MODE != 0 || CW'(k) >= rr_ptr)) begin
        found = 1'b1;
        gidx  = CW'(k);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && ne[k]) begin
        found = 1'b1;
        gidx  = CW'(k);
      end
    end
  end

  // Load and pop decode. Exactly one channel is popped per load.
  always_comb begin
    grant = found ? (NUM_CH'(1) << gidx) : '0;
    load  = (!out_req || out_ack) && found;
    pop   = load ? grant : '0;
    push  = in_vld & in_rdy;
    head  = mem[gidx][rd_ptr[gidx]];
  end

  // Next fill count per channel. A simultaneous push and pop cancel out.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_nxt[k] = cnt[k];
      case ({push[k], pop[k]})
        2'b10:   cnt_nxt[k] = cnt[k] + ONE_CNT;
        2'b01:   cnt_nxt[k] = cnt[k] - ONE_CNT;
        default: cnt_nxt[k] = cnt[k];
      endcase
    end
  end

  // FIFO pointers, counts and the registered ready per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      in_rdy <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + ONE_PTR;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + ONE_PTR;
        cnt[k]    <= cnt_nxt[k];
        in_rdy[k] <= (cnt_nxt[k] != FULL_CNT);
      end
    end
  end

  // FIFO storage. The data is not reset; the counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= in_data[k*DW +: DW];
    end
  end

  // Output register and round-robin pointer. The register reloads whenever
  // it is free or being acked this cycle, so throughput is one word/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_req  <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      out_req  <= 1'b1;
      out_data <= head;
      out_chan <= gidx;
      if (ARB_MODE == 0) rr_ptr <= (gidx == LAST_CH) ? '0 : gidx + ONE_CH;
    end else if (out_ack) begin
      out_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_in_and_out_mux.sv
// Bench for in_and_out_mux. A round-robin instance and a fixed-priority
// instance share the same stimulus. A negedge monitor scores the
// round-robin instance against per-channel expected data.
module tb_in_and_out_mux;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]    in_vld  = '0;
  logic [NUM_CH*DW-1:0] in_data = '0;
  logic                 out_ack = 1'b0;

  logic [NUM_CH-1:0] rr_in_rdy, rr_ch_full, rr_ch_empty;
  logic              rr_out_req;
  logic [DW-1:0]     rr_out_data;
  logic [CW-1:0]     rr_out_chan;
  logic [NUM_CH-1:0] fp_in_rdy, fp_ch_full, fp_ch_empty;
  logic              fp_out_req;
  logic [DW-1:0]     fp_out_data;
  logic [CW-1:0]     fp_out_chan;

  in_and_out_mux #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rr_in_rdy), .in_data(in_data),
    .out_req(rr_out_req), .out_ack(out_ack), .out_data(rr_out_data), .out_chan(rr_out_chan),
    .ch_full(rr_ch_full), .ch_empty(rr_ch_empty)
  );

  in_and_out_mux #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(fp_in_rdy), .in_data(in_data),
    .out_req(fp_out_req), .out_ack(out_ack), .out_data(fp_out_data), .out_chan(fp_out_chan),
    .ch_full(fp_ch_full), .ch_empty(fp_ch_empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [CW+DW-1:0] exp_q[$];
  logic [CW-1:0]    rr_seq[$];
  logic [CW+DW-1:0] fp_seq[$];

  // Inputs settle #1 after posedge, so the negedge sees exactly what the next edge will take.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_CH; i++)
        if (in_vld[i] && rr_in_rdy[i]) exp_q.push_back({CW'(i), in_data[i*DW +: DW]});
      if (rr_out_req && out_ack) begin
        int idx;
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (idx < 0 && exp_q[j][CW+DW-1:DW] == rr_out_chan) idx = j;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL sb_unexpected: got chan %0d data %0h, expected no word", rr_out_chan, rr_out_data);
        end else begin
          if (exp_q[idx][DW-1:0] !== rr_out_data) begin
            errors++;
            $display("FAIL sb_data: chan %0d got %0h expected %0h", rr_out_chan, rr_out_data, exp_q[idx][DW-1:0]);
          end
          exp_q.delete(idx);
        end
        rr_seq.push_back(rr_out_chan);
      end
      if (fp_out_req && out_ack) fp_seq.push_back({fp_out_chan, fp_out_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_word(input int ch, input logic [DW-1:0] val);
    in_data[ch*DW +: DW] = val;
  endtask

  task automatic do_reset();
    in_vld  = '0;
    out_ack = 1'b0;
    rst_n   = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_req(input string name);
    int guard;
    guard = 0;
    while (!rr_out_req && guard < 20) begin
      tick();
      guard++;
    end
    if (!rr_out_req) chk({name, "_timeout"}, 64'(rr_out_req), 64'd1);
  endtask

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          ack_wait;
    int          exp_lat;
    logic [1:0]  exp_chan;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    int lat, n, guard;
    logic [DW-1:0] d0;
    logic [CW-1:0] c0;
    logic [1:0] exp_rr [8];
    logic [1:0] exp_fp [8];

    vecs[0] = '{2, 32'hA5A5_0002, 0, 2, 2'd2, 32'hA5A5_0002};
    vecs[1] = '{0, 32'h1234_5678, 0, 2, 2'd0, 32'h1234_5678};
    vecs[2] = '{3, 32'hFFFF_FFFF, 3, 2, 2'd3, 32'hFFFF_FFFF};
    vecs[3] = '{1, 32'h0000_0000, 1, 2, 2'd1, 32'h0000_0000};
    vecs[4] = '{2, 32'hDEAD_BEEF, 2, 2, 2'd2, 32'hDEAD_BEEF};
    vecs[5] = '{3, 32'h8000_0001, 0, 2, 2'd3, 32'h8000_0001};

    // Reset values, observed while rst_n is low.
    #1;
    chk("rst_out_req",  64'(rr_out_req),  64'd0);
    chk("rst_out_data", 64'(rr_out_data), 64'd0);
    chk("rst_out_chan", 64'(rr_out_chan), 64'd0);
    chk("rst_ch_empty", 64'(rr_ch_empty), 64'hF);
    chk("rst_ch_full",  64'(rr_ch_full),  64'h0);
    chk("rst_in_rdy",   64'(rr_in_rdy),   64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", 64'(rr_in_rdy), 64'hF);

    // Single-word vectors: latency, tagging and hold under a delayed ack.
    for (int v = 0; v < 6; v++) begin
      set_word(vecs[v].ch, vecs[v].data);
      in_vld[vecs[v].ch] = 1'b1;
      out_ack = (vecs[v].ack_wait == 0);
      tick();
      in_vld = '0;
      lat = 1;
      while (!rr_out_req && lat < 10) begin
        tick();
        lat++;
      end
      chk("vec_latency", 64'(lat), 64'(vecs[v].exp_lat));
      chk("vec_chan", 64'(rr_out_chan), 64'(vecs[v].exp_chan));
      chk("vec_data", 64'(rr_out_data), 64'(vecs[v].exp_data));
      for (int w = 0; w < vecs[v].ack_wait; w++) begin
        tick();
        chk("vec_hold_req",  64'(rr_out_req),  64'd1);
        chk("vec_hold_data", 64'(rr_out_data), 64'(vecs[v].exp_data));
      end
      out_ack = 1'b1;
      tick();
      chk("vec_req_drop", 64'(rr_out_req), 64'd0);
      out_ack = 1'b0;
      tick();
    end

    // Fill and stall on channel 0: output register plus a full FIFO absorb 5 words.
    do_reset();
    n = 0;
    guard = 0;
    while (n < 5 && guard < 20) begin
      logic acc;
      set_word(0, 32'h0F00_0000 + 32'(n));
      in_vld[0] = 1'b1;
      acc = rr_in_rdy[0];
      tick();
      guard++;
      if (acc) n++;
    end
    in_vld = '0;
    chk("fill_words",   64'(n),             64'd5);
    chk("fill_cycles",  64'(guard),         64'd5);
    chk("fill_full",    64'(rr_ch_full[0]), 64'd1);
    chk("fill_rdy_low", 64'(rr_in_rdy[0]),  64'd0);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("fill_rdy_back", 64'(rr_in_rdy[0]),  64'd1);
    chk("fill_not_full", 64'(rr_ch_full[0]), 64'd0);
    chk("fill_reload",   64'(rr_out_req),    64'd1);
    out_ack = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    out_ack = 1'b0;
    chk("fill_drained", 64'(exp_q.size()), 64'd0);
    chk("fill_req_off", 64'(rr_out_req),   64'd0);

    // Held request: out_ack low for 10 cycles while other words arrive.
    set_word(1, 32'h4444_0001);
    in_vld[1] = 1'b1;
    tick();
    in_vld = '0;
    wait_req("hold");
    d0 = rr_out_data;
    c0 = rr_out_chan;
    chk("hold_first", 64'(d0), 64'h4444_0001);
    for (int c = 0; c < 10; c++) begin
      in_vld = '0;
      set_word(c % 4, 32'($urandom_range(0, 32'hFFFF)) | (32'(c) << 24));
      in_vld[c % 4] = 1'b1;
      tick();
      chk("hold_data", 64'(rr_out_data), 64'(d0));
      chk("hold_chan", 64'(rr_out_chan), 64'(c0));
    end
    in_vld = '0;
    out_ack = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    out_ack = 1'b0;
    chk("hold_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with a pending word and partly filled FIFOs.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NUM_CH; i++) set_word(i, 32'h7700_0000 + 32'(i * 16 + c));
      in_vld = '1;
      tick();
    end
    in_vld = '0;
    tick();
    chk("mid_req_before", 64'(rr_out_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_req_async",   64'(rr_out_req),  64'd0);
    chk("mid_empty_async", 64'(rr_ch_empty), 64'hF);
    chk("mid_rdy_async",   64'(rr_in_rdy),   64'h0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ack = 1'b1;
    tick();
    chk("mid_rdy_back", 64'(rr_in_rdy), 64'hF);
    for (int i = 0; i < 5; i++) begin
      chk("mid_no_stale", 64'(rr_out_req), 64'd0);
      tick();
    end
    out_ack = 1'b0;

    // Arbitration: 2 words per channel, then ack held high for 8 cycles.
    do_reset();
    rr_seq.delete();
    fp_seq.delete();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < NUM_CH; i++) set_word(i, 32'hC0DE_0000 | 32'(i << 4) | 32'(w));
      in_vld = '1;
      tick();
    end
    in_vld = '0;
    out_ack = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rr_count", 64'(rr_seq.size()), 64'd8);
    chk("fp_count", 64'(fp_seq.size()), 64'd8);
    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_fp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int k = 0; k < 8; k++) begin
      if (k < rr_seq.size()) chk("rr_chan_seq", 64'(rr_seq[k]), 64'(exp_rr[k]));
      if (k < fp_seq.size())
        chk("fp_word_seq", 64'(fp_seq[k]),
            64'({exp_fp[k], 32'hC0DE_0000 | 32'(k / 2 << 4) | 32'(k % 2)}));
    end
    chk("arb_rr_idle", 64'(rr_out_req), 64'd0);
    chk("arb_fp_idle", 64'(fp_out_req), 64'd0);
    chk("arb_drained", 64'(exp_q.size()), 64'd0);
    out_ack = 1'b0;
    tick();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
